sequenciador_acesso: RTL and testbench
======================================

Name: sequenciador_acesso

Overview:
Upstream front-end for the permission verifier. Collects a 3-bit user code and then a 3-bit function code from switches, confirming each with a button. It drives both codes into the verifier and samples the verifier's 3-bit result. It then shows grant or deny for a fixed time, and locks the panel after repeated denials.

Parameters:
SHOW_CYCLES, 8, cycles grant/deny indication is held
MAX_DENY, 3, consecutive denials that trigger lockout
LOCK_CYCLES, 16, lockout duration in cycles
TIMEOUT_CYCLES, 32, max idle cycles in GET_FUNC before abort
DEBOUNCE_CYCLES, 4, stable-sample count (used only with DEBOUNCE_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
sw  in  3  code switches (user or function, depending on state)
confirm  in  1  confirm button, active-high level
cancel  in  1  cancel button, active-high level, synchronous
perm_in  in  3  verifier result; 000 = no permission
user_out  out  3  registered user code to verifier
func_out  out  3  registered function code to verifier
granted_func  out  3  latched granted function, 000 when not granted
grant  out  1  high during grant display
deny  out  1  high during deny display
locked  out  1  high during lockout
busy  out  1  high in any state except IDLE

Behaviour:
- Interface: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset: state = IDLE. user_out, func_out and granted_func = 000. grant, deny, locked and busy = 0. Deny and timer counters = 0.
- Internal confirm_p: one-cycle pulse on each 0->1 transition of confirm (previous-sample register). Holding confirm produces exactly one pulse.
- IDLE:
  - on confirm_p, user_out <= sw and go to GET_FUNC; timer cleared.
  - cancel only clears user_out and func_out.
- GET_FUNC:
  - on confirm_p, func_out <= sw and go to CHECK.
  - on cancel, user_out and func_out <= 000 and go to IDLE.
  - cancel and confirm_p in the same cycle: cancel wins.
  - timer reaching TIMEOUT_CYCLES-1 with no pulse: same as cancel.
- CHECK: exactly one cycle. perm_in is valid because it derives combinationally from the registered codes. granted_func <= perm_in.
  - perm_in != 000: deny count cleared, go to SHOW_GRANT.
  - perm_in == 000 and deny count+1 == MAX_DENY: go to LOCKOUT.
  - perm_in == 000 otherwise: deny count incremented, go to SHOW_DENY.
- Latency: grant or deny rises 2 cycles after the cycle in which confirm_p occurs in GET_FUNC.
- SHOW_GRANT / SHOW_DENY: grant (or deny) is high for exactly SHOW_CYCLES cycles. Then go to IDLE, with user_out, func_out and granted_func cleared to 000.
- LOCKOUT: locked is high for exactly LOCK_CYCLES cycles. Then deny count <= 0 and go to IDLE.
- Ignored inputs: confirm and cancel are ignored in CHECK, SHOW_* and LOCKOUT. Edge history is still tracked, so a press held across the exit does not fire on entry to IDLE.
- Counter widths: $clog2 of the parameter, minimum 1 bit.
- Deny count: saturates only via lockout and never wraps.
- Reset mid-operation: any state returns immediately to reset values.
- All outputs are registered.

Optional Feature:
DEBOUNCE_EN
- Defined: confirm and cancel each pass through a 2-flop synchronizer and a stability filter. The filtered level changes only after DEBOUNCE_CYCLES consecutive equal samples. Edge detection uses the filtered level, which adds DEBOUNCE_CYCLES+2 cycles of latency.
- Undefined: inputs are treated as clean and synchronous, and edge detection is applied directly.

Decomposition:
Shared package acesso_pkg holds:
- CODE_W = 3
- CODE_NONE = 3'b000
- the state enum: IDLE, GET_FUNC, CHECK, SHOW_GRANT, SHOW_DENY, LOCKOUT

One sub-module, filtro_botao:
- edge pulse output
- optional synchronizer/debounce under DEBOUNCE_EN
- instantiated once for confirm and once for cancel

Test Plan:
- user 101, func 111, verifier attached -> func_out = 111; grant high 8 cycles starting 2 cycles after the second pulse; granted_func = 111; then IDLE with all codes 000.
- user 110, func 010 -> deny high 8 cycles, granted_func = 000, deny count = 1.
- Three consecutive denials (user 100, func 001) -> third CHECK goes to LOCKOUT, locked high 16 cycles with no deny pulse. Presses during lockout are ignored. Afterwards a valid request (user 011, func 010) grants 010.
- user 001 entered, no further press for 32 cycles -> return to IDLE, user_out = 000, busy = 0. Cancel and confirm in the same cycle in GET_FUNC -> IDLE.
- confirm held high for 20 cycles in IDLE -> exactly one capture.
- rst_n asserted during SHOW_GRANT -> outputs reach reset values asynchronously, with no clock edge needed.

Source files
------------

// File: rtl/acesso_pkg.sv
// -----------------------------------------------------------------------------
// acesso_pkg
// Shared definitions for the access sequencer front-end: code width, the
// "no permission" code, the sequencer state encoding and a counter-width
// helper used to size the internal timers.
// -----------------------------------------------------------------------------
package acesso_pkg;

  localparam int CODE_W = 3;
  localparam logic [CODE_W-1:0] CODE_NONE = 3'b000;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GET_FUNC   = 3'd1,
    CHECK      = 3'd2,
    SHOW_GRANT = 3'd3,
    SHOW_DENY  = 3'd4,
    LOCKOUT    = 3'd5
  } state_t;

  // Width of a counter that counts 0 .. n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/filtro_botao.sv
// -----------------------------------------------------------------------------
// filtro_botao
// Button conditioner: produces a clean level and a one-cycle pulse on each
// 0->1 transition of that level.
//
// Build option: DEBOUNCE_EN
//   defined   - input goes through a 2-flop synchronizer and a stability
//               filter; the level changes only after DEBOUNCE_CYCLES
//               consecutive samples that differ from the current level.
//   undefined - input is taken as clean and synchronous.
//
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   btn    in  raw button level
//   level  out conditioned level
//   pulse  out one-cycle pulse on each rising edge of level
// -----------------------------------------------------------------------------
module filtro_botao
  import acesso_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic pulse
);

  logic level_q;

`ifdef DEBOUNCE_EN
  localparam int DB_W = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            filt_q;
  logic [DB_W-1:0] db_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync_q <= {sync_q[0], btn};
      // Any sample equal to the current level restarts the stability count.
      if (sync_q[1] == filt_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        filt_q <= sync_q[1];
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign level = filt_q;
`else
  // Keeps the filter length referenced when filtering is compiled out.
  logic [31:0] unused_cfg;
  assign unused_cfg = 32'(DEBOUNCE_CYCLES);

  assign level = btn;
`endif

  // Previous-sample register for edge detection; it runs in every state so a
  // press held across a state change never fires late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/sequenciador_acesso.sv
// -----------------------------------------------------------------------------
// sequenciador_acesso
// Front-end for the permission verifier. Collects a user code and then a
// function code from the switches (each confirmed by a button press), drives
// them to the verifier, samples its result for one cycle, shows grant or deny
// for SHOW_CYCLES cycles and locks the panel for LOCK_CYCLES cycles after
// MAX_DENY consecutive denials. GET_FUNC aborts after TIMEOUT_CYCLES idle
// cycles.
//
// Build option: DEBOUNCE_EN (see filtro_botao) conditions confirm and cancel.
//
// Ports:
//   clk           in  system clock, rising edge
//   rst_n         in  asynchronous active-low reset
//   sw[2:0]       in  code switches
//   confirm       in  confirm button, active-high level
//   cancel        in  cancel button, active-high level
//   perm_in[2:0]  in  verifier result, 000 = no permission
//   user_out[2:0] out registered user code to verifier
//   func_out[2:0] out registered function code to verifier
//   granted_func  out latched granted function, 000 when not granted
//   grant         out high during grant display
//   deny          out high during deny display
//   locked        out high during lockout
//   busy          out high in any state except IDLE
// -----------------------------------------------------------------------------
module sequenciador_acesso
  import acesso_pkg::*;
#(
  parameter int SHOW_CYCLES     = 8,
  parameter int MAX_DENY        = 3,
  parameter int LOCK_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES  = 32,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] sw,
  input  logic              confirm,
  input  logic              cancel,
  input  logic [CODE_W-1:0] perm_in,
  output logic [CODE_W-1:0] user_out,
  output logic [CODE_W-1:0] func_out,
  output logic [CODE_W-1:0] granted_func,
  output logic              grant,
  output logic              deny,
  output logic              locked,
  output logic              busy
);

  // One timer serves the timeout, the display hold and the lockout, so it is
  // sized for the longest of the three.
  localparam int TIMER_MAX =
    (TIMEOUT_CYCLES > SHOW_CYCLES)
      ? ((TIMEOUT_CYCLES > LOCK_CYCLES) ? TIMEOUT_CYCLES : LOCK_CYCLES)
      : ((SHOW_CYCLES > LOCK_CYCLES) ? SHOW_CYCLES : LOCK_CYCLES);
  localparam int TIMER_W = cnt_w(TIMER_MAX);
  localparam int DENY_W  = cnt_w(MAX_DENY);

  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SHOW_LAST    = TIMER_W'(SHOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST    = TIMER_W'(LOCK_CYCLES - 1);
  localparam logic [DENY_W-1:0]  DENY_LAST    = DENY_W'(MAX_DENY - 1);

  state_t              state, state_next;
  logic [TIMER_W-1:0]  timer;
  logic [DENY_W-1:0]   deny_cnt;

  logic confirm_p, confirm_lvl;
  logic cancel_p,  cancel_lvl;

  filtro_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filtro_confirm (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (confirm),
    .level (confirm_lvl),
    .pulse (confirm_p)
  );

  filtro_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filtro_cancel (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (cancel),
    .level (cancel_lvl),
    .pulse (cancel_p)
  );

  // Confirm acts on its edge, cancel on its level.
  logic unused_btn;
  assign unused_btn = confirm_lvl ^ cancel_p;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves
    // state_next unassigned and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE: begin
        if (confirm_p && !cancel_lvl) state_next = GET_FUNC;
      end
      GET_FUNC: begin
        // Cancel beats a simultaneous confirm; an expired timer acts as cancel.
        if (cancel_lvl || (!confirm_p && timer == TIMEOUT_LAST)) begin
          state_next = IDLE;
        end else if (confirm_p) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (perm_in != CODE_NONE)     state_next = SHOW_GRANT;
        else if (deny_cnt == DENY_LAST) state_next = LOCKOUT;
        else                          state_next = SHOW_DENY;
      end
      SHOW_GRANT, SHOW_DENY: begin
        if (timer == SHOW_LAST) state_next = IDLE;
      end
      LOCKOUT: begin
        if (timer == LOCK_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, timers, codes and registered indications
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      deny_cnt     <= '0;
      user_out     <= CODE_NONE;
      func_out     <= CODE_NONE;
      granted_func <= CODE_NONE;
      grant        <= 1'b0;
      deny         <= 1'b0;
      locked       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state <= state_next;

      // Indications are decoded from the next state so they line up with it.
      busy   <= (state_next != IDLE);
      grant  <= (state_next == SHOW_GRANT);
      deny   <= (state_next == SHOW_DENY);
      locked <= (state_next == LOCKOUT);

      // Timer restarts on every state change and counts cycles spent in the
      // current state.
      if (state_next != state || state == IDLE) timer <= '0;
      else                                      timer <= timer + 1'b1;

      unique case (state)
        IDLE: begin
          if (cancel_lvl) begin
            user_out <= CODE_NONE;
            func_out <= CODE_NONE;
          end else if (confirm_p) begin
            user_out <= sw;
          end
        end
        GET_FUNC: begin
          if (state_next == IDLE) begin
            user_out <= CODE_NONE;
            func_out <= CODE_NONE;
          end else if (confirm_p) begin
            func_out <= sw;
          end
        end
        CHECK: begin
          granted_func <= perm_in;
          // The lockout path leaves the count at MAX_DENY-1; it is cleared
          // when lockout ends, so it never wraps.
          if (perm_in != CODE_NONE)    deny_cnt <= '0;
          else if (deny_cnt != DENY_LAST) deny_cnt <= deny_cnt + 1'b1;
        end
        SHOW_GRANT, SHOW_DENY: begin
          if (state_next == IDLE) begin
            user_out     <= CODE_NONE;
            func_out     <= CODE_NONE;
            granted_func <= CODE_NONE;
          end
        end
        LOCKOUT: begin
          if (state_next == IDLE) deny_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sequenciador_acesso.sv
// -----------------------------------------------------------------------------
// tb_sequenciador_acesso
// Directed bench for sequenciador_acesso. A small verifier model drives
// perm_in from the DUT codes. Stimulus pushes the expected display event
// (kind, start cycle, granted function, function code, duration) into a
// queue; a monitor pops and compares whenever grant, deny or locked rises.
// -----------------------------------------------------------------------------
module tb_sequenciador_acesso;

  localparam int K_GRANT = 0;
  localparam int K_DENY  = 1;
  localparam int K_LOCK  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sw = 3'b000;
  logic       confirm = 1'b0;
  logic       cancel = 1'b0;
  logic [2:0] perm_in;
  logic [2:0] user_out, func_out, granted_func;
  logic       grant, deny, locked, busy;

  always #5 clk = ~clk;

  // Verifier: two permitted (user, function) pairs; grants the function.
  always_comb begin
    perm_in = 3'b000;
    if ((user_out == 3'b101 && func_out == 3'b111) ||
        (user_out == 3'b011 && func_out == 3'b010))
      perm_in = func_out;
  end

  sequenciador_acesso dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw           (sw),
    .confirm      (confirm),
    .cancel       (cancel),
    .perm_in      (perm_in),
    .user_out     (user_out),
    .func_out     (func_out),
    .granted_func (granted_func),
    .grant        (grant),
    .deny         (deny),
    .locked       (locked),
    .busy         (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    int         start;
    logic [2:0] gfunc;
    logic [2:0] func;
    int         len;    // 0: duration not checked
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic pg = 1'b0, pd = 1'b0, pl = 1'b0;
  bit   active = 1'b0;
  int   run = 0;
  int   kind;
  exp_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      active = 1'b0;
      pg = 1'b0; pd = 1'b0; pl = 1'b0;
    end else begin
      if (active) begin
        if ((cur.kind == K_GRANT && grant) || (cur.kind == K_DENY && deny) ||
            (cur.kind == K_LOCK && locked)) begin
          run++;
        end else begin
          if (cur.len > 0) check("pulse_len", run, cur.len);
          if (cur.kind != K_LOCK)
            check("codes_cleared", {user_out, func_out, granted_func}, 9'd0);
          active = 1'b0;
        end
      end
      if ((grant && !pg) || (deny && !pd) || (locked && !pl)) begin
        kind = grant ? K_GRANT : (deny ? K_DENY : K_LOCK);
        if (sb.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          cur = sb.pop_front();
          check("event_kind", kind, cur.kind);
          check("event_start", cyc, cur.start);
          check("granted_func", granted_func, cur.gfunc);
          check("event_func_out", func_out, cur.func);
          active = 1'b1;
          run = 1;
        end
      end
      pg = grant; pd = deny; pl = locked;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic press(input logic [2:0] v, output int c);
    @(posedge clk); #1;
    sw = v;
    confirm = 1'b1;
    c = cyc;
    @(posedge clk); #1;
    confirm = 1'b0;
  endtask

  // Full request; the event is queued before the DUT can show it.
  task automatic request(input logic [2:0] u, input logic [2:0] f, input int k,
                         input logic [2:0] gf, input int len);
    int c1, c2;
    press(u, c1);
    check("user_captured", user_out, u);
    press(f, c2);
    sb.push_back('{kind: k, start: c2 + 2, gfunc: gf, func: f, len: len});
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("return_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int c;

    // Reset values
    @(negedge clk);
    check("rst_codes", {user_out, func_out, granted_func}, 9'd0);
    check("rst_flags", {grant, deny, locked, busy}, 4'b0000);
    rst_n = 1'b1;

    // Grant: user 101, func 111
    request(3'b101, 3'b111, K_GRANT, 3'b111, 8);
    wait_idle(20);

    // Deny: user 110, func 010 (deny count becomes 1)
    request(3'b110, 3'b010, K_DENY, 3'b000, 8);
    wait_idle(20);

    // Confirm held 20 cycles in IDLE: exactly one capture
    @(posedge clk); #1;
    sw = 3'b101;
    confirm = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("held_user", user_out, 3'b101);
    check("held_busy", busy, 1);
    check("held_no_func", func_out, 3'b000);
    confirm = 1'b0;
    press(3'b111, c);
    sb.push_back('{kind: K_GRANT, start: c + 2, gfunc: 3'b111, func: 3'b111, len: 8});
    wait_idle(20);

    // Grant above cleared the deny count: deny, deny, then lockout
    request(3'b100, 3'b001, K_DENY, 3'b000, 8);
    wait_idle(20);
    request(3'b100, 3'b001, K_DENY, 3'b000, 8);
    wait_idle(20);
    request(3'b100, 3'b001, K_LOCK, 3'b000, 16);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (locked) break;
    end
    check("lock_seen", locked, 1);
    press(3'b111, c);            // ignored during lockout
    press(3'b101, c);            // ignored during lockout
    wait_idle(30);
    check("lock_released", locked, 0);

    // Valid request after lockout
    request(3'b011, 3'b010, K_GRANT, 3'b010, 8);
    wait_idle(20);

    // Timeout in GET_FUNC
    press(3'b001, c);
    check("to_user", user_out, 3'b001);
    while (cyc != c + 32) @(negedge clk);
    check("to_busy_last", busy, 1);
    @(negedge clk);
    check("to_busy_done", busy, 0);
    check("to_user_clr", user_out, 3'b000);

    // Cancel and confirm together in GET_FUNC: cancel wins
    press(3'b001, c);
    check("cc_busy", busy, 1);
    @(posedge clk); #1;
    sw = 3'b110;
    confirm = 1'b1;
    cancel = 1'b1;
    @(posedge clk); #1;
    confirm = 1'b0;
    cancel = 1'b0;
    @(negedge clk);
    check("cc_busy_done", busy, 0);
    check("cc_codes", {user_out, func_out}, 6'd0);
    repeat (4) @(negedge clk);
    check("cc_still_idle", busy, 0);

    // Asynchronous reset during SHOW_GRANT
    request(3'b101, 3'b111, K_GRANT, 3'b111, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (grant) break;
    end
    check("rg_grant_seen", grant, 1);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rg_codes", {user_out, func_out, granted_func}, 9'd0);
    check("rg_flags", {grant, deny, locked, busy}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rg_idle", busy, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
